ccff_chain_loader: RTL



---
 rtl/ccff_loader_pkg.sv | 22 ++
 rtl/ccff_word_serializer.sv | 40 ++++
 rtl/ccff_chain_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Imported by the loader top and its word serializer.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    SETTLE,
    DONE
  } ccff_ld_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Parallel-in/serial-out word register for the config chain.
// Tracks how many bits of the loaded word remain to be shifted.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int LEN_W  = clog2_ceil(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_word_len,
  output logic              o_bit_out,
  output logic              o_empty,
  output logic              o_last
);

  logic [WORD_W-1:0] r_sr;
  logic [LEN_W-1:0]  r_left;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_sr   <= i_data;
      r_left <= i_word_len;
    end else if (i_shift && (r_left != '0)) begin
      r_sr   <= r_sr >> 1;
      r_left <= r_left - LEN_W'(1);
    end
  end

  assign o_bit_out = r_sr[0];
  assign o_empty   = (r_left == '0);
  assign o_last    = (r_left == LEN_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto the ccff chain, gates prog_clk,
// and holds I/O isolation until the chain is loaded and settled.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int ISO_HOLD  = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done
);

  localparam int CW = clog2_ceil(CHAIN_LEN + 1);
  localparam int LW = clog2_ceil(WORD_W + 1);
  localparam int SW = clog2_ceil(ISO_HOLD + 1);

  ccff_ld_state_t r_state;
  ccff_ld_state_t w_next;

  logic [CW-1:0] r_bit_cnt;
  logic [SW-1:0] r_settle;
  logic          r_head_q;

  logic          w_load;
  logic          w_shift;
  logic          w_bit;
  logic          w_empty;
  logic          w_last;
  logic          w_chain_full;
  logic          w_restart;
  logic [LW-1:0] w_len;
  int            w_rem;

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .LEN_W  (LW)
  ) u_ser (
    .clk        (prog_clk),
    .rst_n      (prog_reset_n),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (cfg_data),
    .i_word_len (w_len),
    .o_bit_out  (w_bit),
    .o_empty    (w_empty),
    .o_last     (w_last)
  );

  // Final word may be shorter than WORD_W; its upper bits never shift.
  always_comb begin
    w_rem = CHAIN_LEN - int'(r_bit_cnt);
    w_len = (w_rem < WORD_W) ? LW'(w_rem) : LW'(WORD_W);
  end

  assign w_chain_full = ((int'(r_bit_cnt) + 1) == CHAIN_LEN);
  assign w_restart    = start &&
                        ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = FETCH;
      end
      FETCH: begin
        if (cfg_valid) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_empty) begin
          w_next = FETCH;
        end else begin
          w_shift = 1'b1;
          if (w_last) begin
            if (!w_chain_full)     w_next = FETCH;
            else if (ISO_HOLD == 0) w_next = DONE;
            else                   w_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (int'(r_settle) >= ISO_HOLD - 1) w_next = DONE;
      end
      DONE: begin
        if (start) w_next = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_settle  <= '0;
      r_head_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_restart)    r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + CW'(1);
      if (r_state == SETTLE) r_settle <= r_settle + SW'(1);
      else                   r_settle <= '0;
      if (w_shift) r_head_q <= w_bit;
    end
  end

  // Head follows the live bit while shifting, else holds the last one.
  assign ccff_head   = (r_state == SHIFT) ? w_bit : r_head_q;
  assign cfg_ready   = (r_state == FETCH);
  assign prog_clk_en = (r_state == SHIFT);
  assign IO_ISOL_N   = (r_state == DONE);
  assign done        = (r_state == DONE);
  assign busy        = (r_state == FETCH) ||
                       (r_state == SHIFT) ||
                       (r_state == SETTLE);

endmodule
